// File: rtl/stages_definition_pkg.sv
// ---------------------------------------------------------------------------
// stages_definition_pkg
// Shared types and constants for the pipeline hazard/stall controller.
//   ctrl_state_e    : controller state encoding (RUN / MEMWAIT / ERROR);
//                     encoding 2'd3 is never produced and is decoded as RUN.
//   DEFAULT_TIMEOUT : default number of memory-wait cycles before the
//                     controller gives up and enters ERROR.
// ---------------------------------------------------------------------------
package stages_definition_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    ERROR   = 2'd2
  } ctrl_state_e;

  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_if
// Bundle of the hazard-controller signals between the datapath and the
// controller.
//   Datapath -> controller : branchTaken, memToRegE, rdE, rs1D, rs2D,
//                            useRs1D, useRs2D, memReqM, memAckM
//   Controller -> datapath : stallF/D/E/M, flushF/D/E, ctrlState,
//                            stallCount, memTimeout
//   master : the datapath side (drives requests, receives stalls/flushes)
//   slave  : the controller side (pipeline_ctrl)
// ---------------------------------------------------------------------------
interface pipeline_ctrl_if #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
);

  logic             branchTaken;
  logic             memToRegE;
  logic [REG_W-1:0] rdE;
  logic [REG_W-1:0] rs1D;
  logic [REG_W-1:0] rs2D;
  logic             useRs1D;
  logic             useRs2D;
  logic             memReqM;
  logic             memAckM;

  logic             stallF;
  logic             stallD;
  logic             stallE;
  logic             stallM;
  logic             flushF;
  logic             flushD;
  logic             flushE;
  logic [1:0]       ctrlState;
  logic [CNT_W-1:0] stallCount;
  logic             memTimeout;

  modport master (
    output branchTaken, memToRegE, rdE, rs1D, rs2D, useRs1D, useRs2D,
           memReqM, memAckM,
    input  stallF, stallD, stallE, stallM, flushF, flushD, flushE,
           ctrlState, stallCount, memTimeout
  );

  modport slave (
    input  branchTaken, memToRegE, rdE, rs1D, rs2D, useRs1D, useRs2D,
           memReqM, memAckM,
    output stallF, stallD, stallE, stallM, flushF, flushD, flushE,
           ctrlState, stallCount, memTimeout
  );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset, clears the count
//   clr   : synchronous clear, wins over inc
//   inc   : add one this cycle (ignored once saturated)
//   count : current value
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {WIDTH{1'b0}};
    end else if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Hazard and stall controller for a five-stage pipeline: load-use bubble
// insertion, branch flush, multi-cycle memory wait with a timeout watchdog,
// and a saturating count of stalled cycles.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : pipeline_ctrl_if.slave -- hazard inputs in, stall/flush/debug out
// Stalls and flushes are combinational (Mealy) so a hazard is handled in
// the very cycle it is detected; all are forced low while rst is asserted.
// ---------------------------------------------------------------------------
module pipeline_ctrl
  import stages_definition_pkg::*;
#(
  parameter int REG_W   = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input logic            clk,
  input logic            rst,
  pipeline_ctrl_if.slave bus
);

  localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
  // Wait count seen in the last MEMWAIT cycle before the watchdog fires.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [REG_W-1:0]  REG_ZERO  = {REG_W{1'b0}};

  ctrl_state_e       state_q;
  ctrl_state_e       state_d;
  logic [WAIT_W-1:0] wait_cnt_s;
  logic              wait_clr_s;
  logic              wait_inc_s;
  logic              in_run_s;
  logic              load_use_s;
  logic              mem_stall_s;
  logic              stall_f_s;
  logic              stall_d_s;
  logic              stall_e_s;
  logic              stall_m_s;
  logic              flush_f_s;
  logic              flush_d_s;
  logic              flush_e_s;
  logic              stall_any_s;
  logic [CNT_W-1:0]  stall_cnt_s;

  // Unused encoding 2'd3 behaves exactly like RUN.
  assign in_run_s = (state_q != MEMWAIT) && (state_q != ERROR);

  // Register zero is hard-wired, so a load into it never creates a hazard.
  assign load_use_s = bus.memToRegE && (bus.rdE != REG_ZERO) &&
                      ((bus.useRs1D && (bus.rs1D == bus.rdE)) ||
                       (bus.useRs2D && (bus.rs2D == bus.rdE)));

  assign mem_stall_s = (in_run_s && bus.memReqM && !bus.memAckM) ||
                       ((state_q == MEMWAIT) && !bus.memAckM);

  // Next state plus wait-counter control.
  always_comb begin
    state_d    = state_q;
    wait_clr_s = 1'b0;
    wait_inc_s = 1'b0;
    case (state_q)
      MEMWAIT: begin
        // New requests are ignored here; only the ack or the watchdog matter.
        if (bus.memAckM) begin
          state_d = RUN;
        end else if (wait_cnt_s == WAIT_LAST) begin
          state_d    = ERROR;
          wait_inc_s = 1'b1;
        end else begin
          state_d    = MEMWAIT;
          wait_inc_s = 1'b1;
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        // RUN, and the unused encoding recovering into RUN.
        if (bus.memReqM && !bus.memAckM) begin
          state_d    = MEMWAIT;
          wait_clr_s = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Stall/flush priority: reset, ERROR, memory stall, branch, load-use.
  always_comb begin
    stall_f_s = 1'b0;
    stall_d_s = 1'b0;
    stall_e_s = 1'b0;
    stall_m_s = 1'b0;
    flush_f_s = 1'b0;
    flush_d_s = 1'b0;
    flush_e_s = 1'b0;
    if (!rst) begin
      stall_f_s = 1'b0;
    end else if ((state_q == ERROR) || mem_stall_s) begin
      stall_f_s = 1'b1;
      stall_d_s = 1'b1;
      stall_e_s = 1'b1;
      stall_m_s = 1'b1;
    end else if (bus.branchTaken) begin
      // Decode is discarded, so any load-use bubble there is moot.
      flush_f_s = 1'b1;
      flush_d_s = 1'b1;
    end else if (load_use_s) begin
      // Hold Fetch/Decode and let a bubble into Execute.
      stall_f_s = 1'b1;
      stall_d_s = 1'b1;
      flush_e_s = 1'b1;
    end else begin
      stall_f_s = 1'b0;
    end
  end

  assign stall_any_s = stall_f_s | stall_d_s | stall_e_s | stall_m_s;

  sat_counter #(
    .WIDTH (WAIT_W)
  ) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (wait_clr_s),
    .inc   (wait_inc_s),
    .count (wait_cnt_s)
  );

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (stall_any_s),
    .count (stall_cnt_s)
  );

  assign bus.stallF     = stall_f_s;
  assign bus.stallD     = stall_d_s;
  assign bus.stallE     = stall_e_s;
  assign bus.stallM     = stall_m_s;
  assign bus.flushF     = flush_f_s;
  assign bus.flushD     = flush_d_s;
  assign bus.flushE     = flush_e_s;
  assign bus.ctrlState  = state_q;
  assign bus.stallCount = stall_cnt_s;
  assign bus.memTimeout = (state_q == ERROR);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
// Self-checking bench for pipeline_ctrl. Each cycle the expected
// stall/flush vector, state, stall count and timeout flag are pushed to a
// scoreboard when inputs are driven, then popped and compared on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

  localparam int REG_W   = 4;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 255;

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  // {stallF, stallD, stallE, stallM, flushF, flushD, flushE}
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_MEM  = 7'b1111000;
  localparam logic [6:0] C_LU   = 7'b1100001;
  localparam logic [6:0] C_BR   = 7'b0000110;

  typedef struct {
    logic [6:0]       ctl;
    logic [1:0]       st;
    logic [CNT_W-1:0] cnt;
    logic             tmo;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb[$];
  int   exp_cnt;
  int   n_checks;
  int   n_pass;

  pipeline_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  pipeline_ctrl #(
    .REG_W   (REG_W),
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "bench watchdog expired");
  end

  task automatic set_in(input logic bt, input logic ld, input logic [REG_W-1:0] rd,
                        input logic [REG_W-1:0] r1, input logic [REG_W-1:0] r2,
                        input logic u1, input logic u2, input logic req, input logic ack);
    bus.branchTaken = bt;
    bus.memToRegE   = ld;
    bus.rdE         = rd;
    bus.rs1D        = r1;
    bus.rs2D        = r2;
    bus.useRs1D     = u1;
    bus.useRs2D     = u2;
    bus.memReqM     = req;
    bus.memAckM     = ack;
  endtask

  // Expected count is the value before this cycle's stall is added.
  task automatic push_exp(input logic [6:0] ctl, input logic [1:0] st);
    exp_t e;
    e.ctl = ctl;
    e.st  = st;
    e.cnt = CNT_W'(exp_cnt);
    e.tmo = (st == S_ERR);
    sb.push_back(e);
    if (ctl[6:3] != 4'b0000) exp_cnt++;
  endtask

  function automatic logic [6:0] obs_ctl();
    return {bus.stallF, bus.stallD, bus.stallE, bus.stallM, bus.flushF, bus.flushD, bus.flushE};
  endfunction

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 2) begin
        rst = 1'b1;
        set_in(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      end else begin
        // Load-use, branch and a memory request all present: must be masked.
        set_in(1'b1, 1'b1, 4'd3, 4'd3, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0);
      end
      push_exp(C_NONE, S_RUN);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (obs_ctl() !== e.ctl) $display("FAIL reset ctl cyc %0d: got %b expected %b", i, obs_ctl(), e.ctl);
      else n_pass++;
      n_checks++;
      if (bus.ctrlState !== e.st) $display("FAIL reset state cyc %0d: got %0d expected %0d", i, bus.ctrlState, e.st);
      else n_pass++;
      n_checks++;
      if (bus.stallCount !== e.cnt) $display("FAIL reset count cyc %0d: got %0d expected %0d", i, bus.stallCount, e.cnt);
      else n_pass++;
      n_checks++;
      if (bus.memTimeout !== e.tmo) $display("FAIL reset timeout cyc %0d: got %b expected %b", i, bus.memTimeout, e.tmo);
      else n_pass++;
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      case (i)
        0: begin set_in(1'b0, 1'b1, 4'd5, 4'd5, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0); push_exp(C_LU, S_RUN); end
        1: begin set_in(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0); push_exp(C_NONE, S_RUN); end
        2: begin set_in(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0); push_exp(C_NONE, S_RUN); end
        3: begin set_in(1'b1, 1'b1, 4'd5, 4'd5, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0); push_exp(C_BR, S_RUN); end
        4: begin set_in(1'b0, 1'b1, 4'd7, 4'd5, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0); push_exp(C_LU, S_RUN); end
        5: begin set_in(1'b0, 1'b1, 4'd5, 4'd5, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0); push_exp(C_NONE, S_RUN); end
        6: begin set_in(1'b0, 1'b0, 4'd5, 4'd5, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0); push_exp(C_NONE, S_RUN); end
        default: begin set_in(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0); push_exp(C_NONE, S_RUN); end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (obs_ctl() !== e.ctl) $display("FAIL load_use ctl cyc %0d: got %b expected %b", i, obs_ctl(), e.ctl);
      else n_pass++;
      n_checks++;
      if (bus.ctrlState !== e.st) $display("FAIL load_use state cyc %0d: got %0d expected %0d", i, bus.ctrlState, e.st);
      else n_pass++;
      n_checks++;
      if (bus.stallCount !== e.cnt) $display("FAIL load_use count cyc %0d: got %0d expected %0d", i, bus.stallCount, e.cnt);
      else n_pass++;
      n_checks++;
      if (bus.memTimeout !== e.tmo) $display("FAIL load_use timeout cyc %0d: got %b expected %b", i, bus.memTimeout, e.tmo);
      else n_pass++;
    end
  endtask

  task automatic test_mem_wait();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      case (i)
        0: begin set_in(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0); push_exp(C_MEM, S_RUN); end
        // A second request while waiting is ignored.
        1: begin set_in(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0); push_exp(C_MEM, S_WAIT); end
        2: begin set_in(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0); push_exp(C_MEM, S_WAIT); end
        3: begin set_in(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1); push_exp(C_NONE, S_WAIT); end
        default: begin set_in(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0); push_exp(C_NONE, S_RUN); end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (obs_ctl() !== e.ctl) $display("FAIL mem_wait ctl cyc %0d: got %b expected %b", i, obs_ctl(), e.ctl);
      else n_pass++;
      n_checks++;
      if (bus.ctrlState !== e.st) $display("FAIL mem_wait state cyc %0d: got %0d expected %0d", i, bus.ctrlState, e.st);
      else n_pass++;
      n_checks++;
      if (bus.stallCount !== e.cnt) $display("FAIL mem_wait count cyc %0d: got %0d expected %0d", i, bus.stallCount, e.cnt);
      else n_pass++;
      n_checks++;
      if (bus.memTimeout !== e.tmo) $display("FAIL mem_wait timeout cyc %0d: got %b expected %b", i, bus.memTimeout, e.tmo);
      else n_pass++;
    end
  endtask

  task automatic test_branch_during_wait();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      case (i)
        0: begin set_in(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0); push_exp(C_MEM, S_RUN); end
        1: begin set_in(1'b1, 1'b1, 4'd2, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0); push_exp(C_MEM, S_WAIT); end
        2: begin set_in(1'b1, 1'b1, 4'd2, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1); push_exp(C_BR, S_WAIT); end
        default: begin set_in(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0); push_exp(C_NONE, S_RUN); end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (obs_ctl() !== e.ctl) $display("FAIL br_wait ctl cyc %0d: got %b expected %b", i, obs_ctl(), e.ctl);
      else n_pass++;
      n_checks++;
      if (bus.ctrlState !== e.st) $display("FAIL br_wait state cyc %0d: got %0d expected %0d", i, bus.ctrlState, e.st);
      else n_pass++;
      n_checks++;
      if (bus.stallCount !== e.cnt) $display("FAIL br_wait count cyc %0d: got %0d expected %0d", i, bus.stallCount, e.cnt);
      else n_pass++;
      n_checks++;
      if (bus.memTimeout !== e.tmo) $display("FAIL br_wait timeout cyc %0d: got %b expected %b", i, bus.memTimeout, e.tmo);
      else n_pass++;
    end
  endtask

  task automatic test_req_ack_same();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      case (i)
        0: set_in(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        1: set_in(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        default: set_in(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      endcase
      push_exp(C_NONE, S_RUN);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (obs_ctl() !== e.ctl) $display("FAIL req_ack ctl cyc %0d: got %b expected %b", i, obs_ctl(), e.ctl);
      else n_pass++;
      n_checks++;
      if (bus.ctrlState !== e.st) $display("FAIL req_ack state cyc %0d: got %0d expected %0d", i, bus.ctrlState, e.st);
      else n_pass++;
      n_checks++;
      if (bus.stallCount !== e.cnt) $display("FAIL req_ack count cyc %0d: got %0d expected %0d", i, bus.stallCount, e.cnt);
      else n_pass++;
      n_checks++;
      if (bus.memTimeout !== e.tmo) $display("FAIL req_ack timeout cyc %0d: got %b expected %b", i, bus.memTimeout, e.tmo);
      else n_pass++;
    end
  endtask

  // Request with no ack: TIMEOUT wait cycles, then ERROR, which ignores
  // inputs until an asynchronous reset (checked without a clock edge).
  task automatic test_timeout();
    exp_t e;
    for (int i = 0; i < TIMEOUT + 7; i++) begin
      if (i == TIMEOUT + 5) begin
        @(posedge clk); #2;
        rst = 1'b0;
        exp_cnt = 0;
        #2;
        push_exp(C_NONE, S_RUN);
      end else begin
        @(posedge clk); #1;
        if (i == 0) begin
          set_in(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
          push_exp(C_MEM, S_RUN);
        end else if (i == TIMEOUT + 6) begin
          rst = 1'b1;
          set_in(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
          push_exp(C_NONE, S_RUN);
        end else if (i >= TIMEOUT + 2) begin
          set_in(1'b1, 1'b1, 4'd4, 4'd4, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1);
          push_exp(C_MEM, S_ERR);
        end else begin
          set_in(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
          push_exp(C_MEM, (i <= TIMEOUT) ? S_WAIT : S_ERR);
        end
        @(negedge clk);
      end
      e = sb.pop_front();
      n_checks++;
      if (obs_ctl() !== e.ctl) $display("FAIL timeout ctl cyc %0d: got %b expected %b", i, obs_ctl(), e.ctl);
      else n_pass++;
      n_checks++;
      if (bus.ctrlState !== e.st) $display("FAIL timeout state cyc %0d: got %0d expected %0d", i, bus.ctrlState, e.st);
      else n_pass++;
      n_checks++;
      if (bus.stallCount !== e.cnt) $display("FAIL timeout count cyc %0d: got %0d expected %0d", i, bus.stallCount, e.cnt);
      else n_pass++;
      n_checks++;
      if (bus.memTimeout !== e.tmo) $display("FAIL timeout flag cyc %0d: got %b expected %b", i, bus.memTimeout, e.tmo);
      else n_pass++;
    end
  endtask

  task automatic test_reset_in_wait();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        @(posedge clk); #2;
        rst = 1'b0;
        exp_cnt = 0;
        set_in(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        push_exp(C_NONE, S_RUN);
      end else begin
        @(posedge clk); #1;
        if (i == 3) rst = 1'b1;
        set_in(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, (i == 0), 1'b0);
        case (i)
          0: push_exp(C_MEM, S_RUN);
          1: push_exp(C_MEM, S_WAIT);
          default: push_exp(C_NONE, S_RUN);
        endcase
        @(negedge clk);
      end
      e = sb.pop_front();
      n_checks++;
      if (obs_ctl() !== e.ctl) $display("FAIL rst_wait ctl cyc %0d: got %b expected %b", i, obs_ctl(), e.ctl);
      else n_pass++;
      n_checks++;
      if (bus.ctrlState !== e.st) $display("FAIL rst_wait state cyc %0d: got %0d expected %0d", i, bus.ctrlState, e.st);
      else n_pass++;
      n_checks++;
      if (bus.stallCount !== e.cnt) $display("FAIL rst_wait count cyc %0d: got %0d expected %0d", i, bus.stallCount, e.cnt);
      else n_pass++;
      n_checks++;
      if (bus.memTimeout !== e.tmo) $display("FAIL rst_wait timeout cyc %0d: got %b expected %b", i, bus.memTimeout, e.tmo);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    exp_cnt  = 0;
    rst      = 1'b1;
    set_in(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    rst = 1'b0;

    test_reset();
    test_load_use();
    test_mem_wait();
    test_branch_during_wait();
    test_req_ack_same();
    test_timeout();
    test_reset_in_wait();

    n_checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter REG_W, default 4, register-index width.
REQ-002 Parameter CNT_W, default 16, stall-counter width.
REQ-003 Parameter TIMEOUT, default 255, maximum memory-wait cycles before error.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 branchTaken  in  1  branch resolved taken in Execute.
REQ-007 memToRegE  in  1  Execute instruction is a load.
REQ-008 rdE  in  REG_W  Execute destination register.
REQ-009 rs1D, rs2D  in  REG_W each  Decode source registers.
REQ-010 useRs1D, useRs2D  in  1 each  Decode actually reads rs1D / rs2D.
REQ-011 memReqM  in  1  one-cycle pulse: Memory stage starts a multi-cycle access.
REQ-012 memAckM  in  1  memory access complete, one-cycle pulse.
REQ-013 stallF, stallD, stallE, stallM  out  1 each  hold the corresponding pipeline register.
REQ-014 flushF, flushD, flushE  out  1 each  clear the corresponding pipeline register.
REQ-015 ctrlState  out  2  current state encoding, for debug.
REQ-016 stallCount  out  CNT_W  total stalled cycles since reset, saturating.
REQ-017 memTimeout  out  1  sticky error flag.

Function
REQ-018 States: RUN=0, MEMWAIT=1, ERROR=2; encoding 3 is unreachable and SHALL be treated as RUN.
REQ-019 loadUse = memToRegE && rdE!=0 && ((useRs1D && rs1D==rdE) || (useRs2D && rs2D==rdE)); the check is combinational.
REQ-020 memStall = (RUN && memReqM && !memAckM) || (MEMWAIT && !memAckM); it is a Mealy output with zero-cycle latency.
REQ-021 When memStall is high, stallF, stallD, stallE and stallM SHALL be 1 and all flushes SHALL be 0; memStall has highest priority.
REQ-022 Else, if branchTaken is high, flushF and flushD SHALL be 1 and all stalls 0; the load-use bubble is suppressed because Decode is discarded.
REQ-023 Else, if loadUse is high, stallF=stallD=flushE=1 and stallE=stallM=0, producing a one-bubble insert.
REQ-024 Otherwise all stall and flush outputs SHALL be 0.
REQ-025 Transition RUN->MEMWAIT on memReqM && !memAckM; memReqM && memAckM in the same cycle stays in RUN with no stall.
REQ-026 Transition MEMWAIT->RUN on memAckM; stalls SHALL be deasserted in the ack cycle itself.
REQ-027 memReqM in MEMWAIT SHALL be ignored.
REQ-028 A wait counter SHALL clear on entry to MEMWAIT and increment each MEMWAIT cycle without ack; on reaching TIMEOUT the state SHALL go to ERROR.
REQ-029 In ERROR: memTimeout=1, all four stalls=1, all flushes=0, inputs ignored; ERROR is left only by reset.
REQ-030 stallCount SHALL increment by 1 in each cycle where any stall output is 1, saturating at 2^CNT_W-1.
REQ-031 A branchTaken that arrives during MEMWAIT is held by the stalled Execute stage and SHALL take effect in the first cycle memStall is 0.

Reset
REQ-032 While rst=0: state=RUN, wait counter=0, stallCount=0, memTimeout=0, and all stall and flush outputs 0 regardless of inputs.
REQ-033 Reset asserted mid-MEMWAIT or in ERROR SHALL return to RUN immediately and asynchronously; a pending access is abandoned.
REQ-034 The first state update after deassertion SHALL occur on the next rising clk edge.

Structure
REQ-035 ctrl_state_e (2-bit enum) and the default TIMEOUT constant SHALL be placed in stages_definition_pkg.
REQ-036 One sub-module, sat_counter (parameter width, inc and clr inputs, saturating output), SHALL be instantiated twice: once for the wait counter and once for stallCount.
REQ-037 The next-state logic and the output priority SHALL each be implemented as a single always block.

Verification
REQ-038 Load-use test: memToRegE=1, rdE=5, rs1D=5, useRs1D=1 for one cycle -> stallF=stallD=flushE=1 that cycle, stallCount=1.
REQ-039 Load to register zero: memToRegE=1, rdE=0, rs1D=0 -> no stall and no flush.
REQ-040 Branch with load-use: branchTaken=1 together with the load-use of REQ-038 -> flushF=flushD=1, flushE=0, stallF=0.
REQ-041 Memory wait: memReqM pulse, memAckM 3 cycles later -> stalls high for exactly 3 cycles, ctrlState 1 then 0, stallCount=3.
REQ-042 Timeout: memReqM, no ack for TIMEOUT cycles -> ERROR, memTimeout=1 and stays 1; rst=0 mid-ERROR -> RUN and all outputs 0 with no clock edge.
REQ-043 Simultaneous request and ack: memReqM=memAckM=1 in RUN -> state stays RUN, no stall.
